// File: rtl/bcd_pkg.sv
// Shared types and sizing for the FX33 BCD store sequencer.
// Three BCD digits sit above the 8-bit binary value in a 20-bit shift word.
package bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WRITE_H,
    ST_WRITE_T,
    ST_WRITE_O,
    ST_DONE
  } bcd_state_t;

  localparam int NUM_DIGITS = 3;
  localparam int SHIFT_W    = 20;
  localparam int ITER       = 8;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
// Purely combinational; no handshake.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [SHIFT_W-1:0] din_i,
  output logic [SHIFT_W-1:0] dout_o
);

  logic [SHIFT_W-1:0] adj;

  always_comb begin
    adj = din_i;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (din_i[8+4*d +: 4] >= 4'd5) begin
        adj[8+4*d +: 4] = din_i[8+4*d +: 4] + 4'd3;
      end
    end
    dout_o = adj << 1;
  end

endmodule

// File: rtl/bcd_store_ctrl.sv
// FX33 sequencer: converts VX to BCD, then writes hundreds/tens/ones to I, I+1, I+2; done at +12 (BCD_FAST_EN: +4).
// Each write is held stable until mem_gnt; start is ignored while busy or in DONE.
module bcd_store_ctrl
  import bcd_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        value,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt
);

  bcd_state_t          state_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [ADDR_W-1:0]   base_q;
  logic                busy_q;
  logic                done_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

`ifdef BCD_FAST_EN
  // Eight unrolled steps; the result is captured directly from IDLE.
  logic [SHIFT_W-1:0] chain [ITER+1];
  logic [SHIFT_W-1:0] conv_d;

  assign chain[0] = {{(SHIFT_W-8){1'b0}}, value};
  for (genvar i = 0; i < ITER; i++) begin : g_chain
    bcd_dabble_step u_step (
      .din_i  (chain[i]),
      .dout_o (chain[i+1])
    );
  end
  assign conv_d = chain[ITER];
`else
  localparam int CNT_W = $clog2(ITER);

  logic [CNT_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] step_d;

  bcd_dabble_step u_step (
    .din_i  (shift_q),
    .dout_o (step_d)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifndef BCD_FAST_EN
      cnt_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            busy_q <= 1'b1;
`ifdef BCD_FAST_EN
            shift_q     <= conv_d;
            state_q     <= ST_WRITE_H;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= base_addr;
            mem_wdata_q <= {4'b0, conv_d[SHIFT_W-1 -: 4]};
`else
            shift_q <= {{(SHIFT_W-8){1'b0}}, value};
            cnt_q   <= '0;
            state_q <= ST_CONVERT;
`endif
          end
        end
        ST_CONVERT: begin
`ifdef BCD_FAST_EN
          state_q <= ST_IDLE;
`else
          shift_q <= step_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q     <= ST_WRITE_H;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= base_q;
            mem_wdata_q <= {4'b0, step_d[SHIFT_W-1 -: 4]};
          end
`endif
        end
        ST_WRITE_H: begin
          if (mem_gnt) begin
            state_q     <= ST_WRITE_T;
            mem_addr_q  <= base_q + ADDR_W'(1);
            mem_wdata_q <= {4'b0, shift_q[15:12]};
          end
        end
        ST_WRITE_T: begin
          if (mem_gnt) begin
            state_q     <= ST_WRITE_O;
            mem_addr_q  <= base_q + ADDR_W'(2);
            mem_wdata_q <= {4'b0, shift_q[11:8]};
          end
        end
        ST_WRITE_O: begin
          if (mem_gnt) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bcd_store_ctrl.sv
// Directed bench for bcd_store_ctrl: write order, addresses, digits, latency, stall, ignored start, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_bcd_store_ctrl;

`ifdef BCD_FAST_EN
  localparam int CONV = 0;
  localparam int SA   = 2;
  localparam int SB   = 4;
`else
  localparam int CONV = 8;
  localparam int SA   = 3;
  localparam int SB   = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  value = 8'h00;
  logic [11:0] base_addr = 12'h000;
  logic        mem_gnt = 1'b1;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];
  int busy_cnt = 0;
  int unstable = 0;
  int we_bad = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b1;
  logic [11:0] prev_addr = 12'h000;
  logic [7:0]  prev_data = 8'h00;

  bcd_store_ctrl #(.ADDR_W(12)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we !== mem_req) we_bad++;
    if (reset_n) begin
      if (prev_req && !prev_gnt &&
          (!mem_req || mem_addr != prev_addr || mem_wdata != prev_data)) unstable++;
      if (mem_req && mem_gnt) begin
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(int'(mem_wdata));
        wr_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
    end
    prev_req  = mem_req && reset_n;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr;
    prev_data = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    busy_cnt = 0;
    unstable = 0;
  endtask

  // One FX33 operation; stall withholds grant for that many cycles in WRITE_T,
  // sa/sb are cycles (relative to accept) at which a stray start is pulsed.
  task automatic run_op(input logic [7:0] v, input logic [11:0] base, input int stall,
                        input int sa, input int sb, input int eh, input int et,
                        input int eo, input string tag);
    int t0;
    int exp_d;
    int exp_c;
    logic [11:0] ea;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1;
    value = v;
    base_addr = base;
    mem_gnt = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == sa) || (c == sb);
      value = ~v;
      base_addr = ~base;
      mem_gnt = !((c >= CONV + 2) && (c < CONV + 2 + stall));
    end
    start = 1'b0;
    mem_gnt = 1'b1;
    chk({tag, ".nwr"}, wr_addr.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      ea = base + 12'(i);
      exp_d = (i == 0) ? eh : (i == 1) ? et : eo;
      exp_c = t0 + CONV + 1 + i + ((i > 0) ? stall : 0);
      chk($sformatf("%s.addr%0d", tag, i), wr_addr[i], int'(ea));
      chk($sformatf("%s.data%0d", tag, i), wr_data[i], exp_d);
      chk($sformatf("%s.cyc%0d", tag, i), wr_cyc[i] - t0, exp_c - t0);
    end
    chk({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({tag, ".done_cyc"}, done_cyc[0] - t0, CONV + 4 + stall);
    chk({tag, ".busy_cycles"}, busy_cnt, CONV + 3 + stall);
    chk({tag, ".stable"}, unstable, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(8'hFF, 12'h300, 0, -1, -1, 2, 5, 5, "ff");
    run_op(8'h00, 12'h010, 0, -1, -1, 0, 0, 0, "zero");
    run_op(8'h09, 12'h020, 0, -1, -1, 0, 0, 9, "nine");
    run_op(8'd123, 12'hFFF, 0, -1, -1, 1, 2, 3, "wrap");
    run_op(8'h57, 12'h400, 5, -1, -1, 0, 8, 7, "stall");
    run_op(8'd200, 12'h500, 0, SA, SB, 2, 0, 0, "ignore");

    // Reset in the middle of WRITE_T abandons the sequence.
    clear_log();
    @(posedge clk); #1;
    start = 1'b1;
    value = 8'h42;
    base_addr = 12'h100;
    mem_gnt = 1'b1;
    for (int c = 1; c <= CONV + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("abort.pre_req", mem_req, 1);
    chk("abort.pre_addr", mem_addr, 12'h101);
    reset_n = 1'b0;
    #1;
    chk("abort.req", mem_req, 0);
    chk("abort.we", mem_we, 0);
    chk("abort.addr", mem_addr, 0);
    chk("abort.wdata", mem_wdata, 0);
    chk("abort.busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort.nwr", wr_addr.size(), 1);
    chk("abort.ndone", done_cyc.size(), 0);
    run_op(8'h42, 12'h100, 0, -1, -1, 0, 6, 6, "after_rst");

    for (int v = 0; v < 256; v++) begin
      run_op(8'(v), 12'(v * 13), 0, -1, -1, v / 100, (v / 10) % 10, v % 10,
             $sformatf("sweep%0d", v));
    end

    chk("we_eq_req", we_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_store_ctrl.md
# bcd_store_ctrl

Sequencer for the Chip-8 FX33 instruction (store BCD of VX at I, I+1, I+2). It accepts a start request with an 8-bit value and a base address, and converts the value to three BCD digits iteratively with shift-and-add-3 (one bit per cycle). It then issues three byte writes through the shared memory-arbiter request/grant port. It sits between the CPU execute stage and the memory arbiter.

## Interface
- ADDR_W, 12, memory address width (4 KiB Chip-8 space)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- value  in  8  binary value (VX); sampled when start is accepted
- base_addr  in  ADDR_W  destination base (I); sampled when start is accepted
- busy  out  1  high in CONVERT and WRITE_* states
- done  out  1  one-cycle completion pulse
- mem_req  out  1  write request to arbiter
- mem_we  out  1  write enable; equals mem_req
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data, {4'b0, digit}
- mem_gnt  in  1  arbiter grant; a write completes in any cycle with mem_req && mem_gnt

## Operation
- States: IDLE, CONVERT, WRITE_H, WRITE_T, WRITE_O, DONE.
- IDLE: if start=1, load shift[19:0] = {12'b0, value}, latch base_addr, clear iteration count, go to CONVERT.
- CONVERT: each cycle, add 3 to each of nibbles [11:8], [15:12] and [19:16] that is >= 5. Then shift the whole register left by 1 and increment the count. After the 8th iteration, go to WRITE_H.
- Digits after conversion: hundreds = shift[19:16], tens = shift[15:12], ones = shift[11:8]. Hundreds is at most 2.
- WRITE_H: mem_req=1, addr=base, data=hundreds. On grant go to WRITE_T.
- WRITE_T: addr=base+1, data=tens. On grant go to WRITE_O.
- WRITE_O: addr=base+2, data=ones. On grant go to DONE.
- Address arithmetic is modulo 2^ADDR_W; base 0xFFF wraps to 0x000, 0x001.
- While mem_gnt=0, mem_req, mem_addr and mem_wdata hold stable and the state does not advance.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE and in all busy states; no queuing.
- Outputs outside WRITE_* states: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; state is IDLE.
- Asserting reset_n=0 in any state forces the reset values immediately, with no clock needed. A partially completed write sequence is abandoned and no further writes occur.
- All outputs are registered or decoded from registered state only. mem_gnt has no combinational path to any output.
- With start accepted at cycle 0 and mem_gnt tied high:
  - CONVERT occupies cycles 1–8.
  - Writes complete at cycles 9, 10 and 11.
  - done is high at cycle 12.
  - busy is high in cycles 1–11.
- Each cycle of withheld grant adds one cycle of latency.

## Configuration
- BCD_FAST_EN defined: conversion is fully combinational (eight unrolled iterations) and is captured in the cycle after start. CONVERT is skipped and the first write is presented at cycle 1. With gnt held high, done is high at cycle 4.
- Undefined: iterative 8-cycle CONVERT as described above.
- The write sequence, handshake and reset behaviour are identical in both configurations.

## Structure
- Package bcd_pkg contains:
  - state enum type bcd_state_t
  - localparam NUM_DIGITS = 3
  - localparam SHIFT_W = 20
  - localparam ITER = 8
- Sub-module bcd_dabble_step: combinational correct-then-shift of one SHIFT_W-bit word.
  - Iterative mode instantiates it once.
  - BCD_FAST_EN instantiates it eight times in a chain.

## Test plan
- value=0xFF, base=0x300, gnt=1: writes 2@0x300, 5@0x301, 5@0x302 at cycles 9/10/11; done at cycle 12.
- value=0x00 and value=0x09: writes 0,0,0 and 0,0,9 respectively. Check each add-3 boundary value 4→5 across all 256 values against a reference model.
- value=123, base=0xFFF: writes 1@0xFFF, 2@0x000, 3@0x001 (address wrap).
- Withhold gnt for 5 cycles during WRITE_T: mem_req, addr and data remain stable; tens is written once; done is delayed by 5 cycles.
- Pulse start at cycles 3 and 10 of an operation: both pulses are ignored; exactly 3 writes and 1 done occur.
- Assert reset_n=0 during WRITE_T: mem_req drops in the same cycle and no write to base+2 occurs. A new start after reset completes normally.
